// File: rtl/neuron_pkg.sv
// Shared encodings and helpers for the streaming neuron datapath.
package neuron_pkg;

  localparam logic [1:0] ACT_IDENTITY = 2'b00;
  localparam logic [1:0] ACT_RELU     = 2'b01;
  localparam logic [1:0] ACT_LEAKY    = 2'b10;
  localparam logic [1:0] ACT_CLAMP    = 2'b11;

  localparam int unsigned LEAK_SHIFT = 2;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    OUT
  } state_t;

  // Smallest r with 2**r >= v (0 for v <= 1).
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/neuron_lane_dot.sv
// Combinational LANES-wide masked multiply with sign-extended sum; lanes at or
// beyond i_cnt are dropped so a short final beat contributes only its valid elements.
module neuron_lane_dot #(
  parameter int unsigned LANES = 4,
  parameter int unsigned X_W   = 8,
  parameter int unsigned W_W   = 8,
  parameter int unsigned ACC_W = 22,
  parameter int unsigned CNT_W = 3
) (
  input  logic [LANES*X_W-1:0]    i_x,
  input  logic [LANES*W_W-1:0]    i_w,
  input  logic [LANES-1:0]        i_mask,
  input  logic [CNT_W-1:0]        i_cnt,
  output logic signed [ACC_W-1:0] o_sum
);

  logic signed [X_W+W_W-1:0] w_prod [LANES];

  always_comb begin
    o_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_prod[k] = $signed(i_x[k*X_W +: X_W]) * $signed(i_w[k*W_W +: W_W]);
      if (i_mask[k] && (32'(i_cnt) > k)) o_sum = o_sum + ACC_W'(w_prod[k]);
    end
  end

endmodule

// File: rtl/neuron_mac_lanes.sv
// Streaming neuron: y = act(sum(mask ? x*w : 0) + bias), LANES products per beat.
// Define NEURON_SAT_FLAG_EN to add the out_sat port (final saturation clipped).
module neuron_mac_lanes
  import neuron_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned MAX_INPUTS = 16,
  parameter int unsigned X_W        = 8,
  parameter int unsigned W_W        = 8,
  parameter int unsigned B_W        = 32,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned X_FRAC     = 4,
  parameter int unsigned W_FRAC     = 4,
  parameter int unsigned B_FRAC     = 8,
  parameter int unsigned OUT_FRAC   = 8,
  parameter int unsigned GUARD_BITS = 2,
  localparam int unsigned LEN_W     = clog2(MAX_INPUTS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [B_W-1:0]   cmd_bias,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic [1:0]              cmd_act,
  input  logic                    data_valid,
  output logic                    data_ready,
  input  logic [LANES*X_W-1:0]    data_x,
  input  logic [LANES*W_W-1:0]    data_w,
  input  logic [LANES-1:0]        data_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    busy
`ifdef NEURON_SAT_FLAG_EN
  ,
  output logic                    out_sat
`endif
);

  localparam int unsigned FRAC_P = X_FRAC + W_FRAC;
  localparam int unsigned LOG_IN = (clog2(MAX_INPUTS) < 1) ? 1 : clog2(MAX_INPUTS);
  localparam int unsigned ACC_W  = X_W + W_W + LOG_IN + GUARD_BITS;
  localparam int unsigned ACC_W1 = ACC_W + 1;
  localparam int unsigned CNT_W  = clog2(LANES + 1);
  localparam int unsigned SH_BR  = (B_FRAC > FRAC_P) ? B_FRAC - FRAC_P : 1;
  localparam int unsigned SH_BL  = (B_FRAC < FRAC_P) ? FRAC_P - B_FRAC : 0;
  localparam int unsigned SH_QR  = (FRAC_P > OUT_FRAC) ? FRAC_P - OUT_FRAC : 1;
  localparam int unsigned SH_QL  = (FRAC_P < OUT_FRAC) ? OUT_FRAC - FRAC_P : 0;
  localparam int unsigned QW     = (ACC_W1 + SH_QL > OUT_W + 1) ? ACC_W1 + SH_QL : OUT_W + 1;
  localparam logic signed [QW-1:0] Q_MAX = QW'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [QW-1:0] Q_MIN = ~Q_MAX;

  // Right shift with round-half-away-from-zero, done on the magnitude.
  function automatic logic signed [ACC_W-1:0] rshift_rnd(input logic signed [ACC_W-1:0] v,
                                                         input int unsigned sh);
    logic signed [ACC_W:0] m;
    m = ACC_W1'(v);
    if (v < 0) m = -m;
    m = (m + (ACC_W1'(1) <<< (sh - 1))) >>> sh;
    if (v < 0) m = -m;
    return ACC_W'(m);
  endfunction

  function automatic logic signed [ACC_W-1:0] align_bias(input logic signed [B_W-1:0] b);
    logic signed [ACC_W-1:0] v;
    v = ACC_W'(b);
    if (B_FRAC > FRAC_P) v = rshift_rnd(v, SH_BR);
    else if (B_FRAC < FRAC_P) v = v <<< SH_BL;
    return v;
  endfunction

  function automatic logic signed [ACC_W-1:0] activate(input logic signed [ACC_W-1:0] v,
                                                       input logic [1:0] act);
    logic signed [ACC_W-1:0] one;
    logic signed [ACC_W-1:0] r;
    one = ACC_W'(1) <<< FRAC_P;
    r   = v;
    case (act)
      ACT_RELU:  if (v < 0) r = '0;
      ACT_LEAKY: if (v < 0) r = v >>> LEAK_SHIFT;
      ACT_CLAMP: begin
        if (v > one) r = one;
        else if (v < -one) r = -one;
      end
      default:   r = v;
    endcase
    return r;
  endfunction

  function automatic logic signed [QW-1:0] requant(input logic signed [ACC_W-1:0] v);
    logic signed [QW-1:0] q;
    if (FRAC_P > OUT_FRAC) q = QW'(rshift_rnd(v, SH_QR));
    else q = QW'(v) <<< SH_QL;
    return q;
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [QW-1:0] q);
    if (q > Q_MAX) return OUT_W'(Q_MAX);
    if (q < Q_MIN) return OUT_W'(Q_MIN);
    return OUT_W'(q);
  endfunction

`ifdef NEURON_SAT_FLAG_EN
  function automatic logic is_clipped(input logic signed [QW-1:0] q);
    return (q > Q_MAX) || (q < Q_MIN);
  endfunction
`endif

  state_t                  r_state;
  logic [1:0]              r_act;
  logic [LEN_W-1:0]        r_rem;
  logic signed [ACC_W-1:0] r_acc;
  logic                    r_cmd_ready;
  logic                    r_data_ready;
  logic                    r_out_valid;
  logic                    r_busy;
  logic signed [OUT_W-1:0] r_out_data;
`ifdef NEURON_SAT_FLAG_EN
  logic                    r_out_sat;
`endif

  logic signed [ACC_W-1:0] w_partial;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_bias_al;
  logic [LEN_W-1:0]        w_len;
  logic [CNT_W-1:0]        w_cnt;
  logic                    w_last;
  logic signed [QW-1:0]    w_q_beat;
  logic signed [QW-1:0]    w_q_bias;

  neuron_lane_dot #(
    .LANES (LANES),
    .X_W   (X_W),
    .W_W   (W_W),
    .ACC_W (ACC_W),
    .CNT_W (CNT_W)
  ) u_dot (
    .i_x    (data_x),
    .i_w    (data_w),
    .i_mask (data_mask),
    .i_cnt  (w_cnt),
    .o_sum  (w_partial)
  );

  // r_rem counts elements still to arrive; it doubles as the final-beat lane limit.
  always_comb begin
    w_len      = (cmd_len > LEN_W'(MAX_INPUTS)) ? LEN_W'(MAX_INPUTS) : cmd_len;
    w_cnt      = (32'(r_rem) >= LANES) ? CNT_W'(LANES) : CNT_W'(r_rem);
    w_last     = (32'(r_rem) <= LANES);
    w_bias_al  = align_bias(cmd_bias);
    w_acc_next = r_acc + w_partial;
    w_q_beat   = requant(activate(w_acc_next, r_act));
    w_q_bias   = requant(activate(w_bias_al, cmd_act));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_act        <= '0;
      r_rem        <= '0;
      r_acc        <= '0;
      r_cmd_ready  <= 1'b1;
      r_data_ready <= 1'b0;
      r_out_valid  <= 1'b0;
      r_busy       <= 1'b0;
      r_out_data   <= '0;
`ifdef NEURON_SAT_FLAG_EN
      r_out_sat    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (cmd_valid) begin
          r_act       <= cmd_act;
          r_rem       <= w_len;
          r_acc       <= w_bias_al;
          r_cmd_ready <= 1'b0;
          r_busy      <= 1'b1;
          if (w_len == '0) begin
            r_state     <= OUT;
            r_out_valid <= 1'b1;
            r_out_data  <= sat_out(w_q_bias);
`ifdef NEURON_SAT_FLAG_EN
            r_out_sat   <= is_clipped(w_q_bias);
`endif
          end else begin
            r_state      <= ACCUM;
            r_data_ready <= 1'b1;
          end
        end
        ACCUM: if (data_valid) begin
          r_acc <= w_acc_next;
          if (w_last) begin
            r_rem        <= '0;
            r_state      <= OUT;
            r_data_ready <= 1'b0;
            r_out_valid  <= 1'b1;
            r_out_data   <= sat_out(w_q_beat);
`ifdef NEURON_SAT_FLAG_EN
            r_out_sat    <= is_clipped(w_q_beat);
`endif
          end else begin
            r_rem <= r_rem - LEN_W'(LANES);
          end
        end
        OUT: if (out_ready) begin
          r_state     <= IDLE;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_cmd_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign data_ready = r_data_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
`ifdef NEURON_SAT_FLAG_EN
  assign out_sat    = r_out_sat;
`endif

endmodule

// File: doc/neuron_mac_lanes.md
Name: neuron_mac_lanes

Overview:
Multi-lane streaming neuron with runtime vector length. Computes y = act(sum over i < len of (mask[i] ? x[i]*w[i] : 0) + bias), with LANES products per beat. Operands stream over a valid/ready data channel instead of a latched flat vector. Sits between the weight/activation feeders and the layer output buffer; the output channel supports backpressure.

Parameters:
LANES, 4, multiplier lanes per beat (>=1)
MAX_INPUTS, 16, maximum vector length per operation (>=1)
X_W, 8, signed input sample width
W_W, 8, signed weight width
B_W, 32, signed bias width
OUT_W, 16, signed output width
X_FRAC, 4, fractional bits of x
W_FRAC, 4, fractional bits of w
B_FRAC, 8, fractional bits of bias
OUT_FRAC, 8, fractional bits of output
GUARD_BITS, 2, extra accumulator headroom

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_bias  in  B_W  signed bias (B_FRAC)
cmd_len  in  LEN_W=clog2(MAX_INPUTS+1)  element count, 0..MAX_INPUTS
cmd_act  in  2  00 identity, 01 ReLU, 10 leaky (>>>2), 11 clamp [-1.0,+1.0]
data_valid  in  1  operand beat offered
data_ready  out  1  beat accepted when both high
data_x  in  LANES*X_W  lane k at [k*X_W +: X_W]
data_w  in  LANES*W_W  lane k at [k*W_W +: W_W]
data_mask  in  LANES  1 = use lane product
out_valid  out  1  result held until accepted
out_ready  in  1  downstream accepts
out_data  out  OUT_W  signed result (OUT_FRAC)
busy  out  1  state != IDLE

Behaviour:
- Reset is rst_n, asynchronous, active-low; the clock is clk. Reset forces state IDLE and clears out_valid, out_data, busy, the accumulator and the counters. Reset mid-operation discards all partial work.
- FRAC_P = X_FRAC+W_FRAC. ACC_W = X_W+W_W+clog2(MAX_INPUTS)+GUARD_BITS, with clog2(MAX_INPUTS) taken as at least 1.
- States:
  - IDLE: cmd_ready=1. On cmd handshake, latch act and min(len, MAX_INPUTS); set acc = align(bias). If the latched len is 0, go to OUT. Otherwise go to ACCUM.
  - ACCUM: data_ready=1. Each accepted beat adds the sum of the masked lane products. Element index is beat*LANES+k. Lanes with index >= len contribute 0 on the final partial beat. Beats = ceil(len/LANES). On the last beat, out_data <= quantize(acc_next) and the state goes to OUT.
  - OUT: out_valid=1, and out_data is held stable. On out_ready, the state goes to IDLE. No command is accepted in the same cycle as an output handshake.
- Latency: out_valid rises 1 cycle after the last beat handshake, or 1 cycle after the command handshake when len = 0.
- Bias alignment:
  - Sign-extend, or truncate, into ACC_W.
  - If B_FRAC > FRAC_P, shift right with round-half-away-from-zero.
  - If B_FRAC < FRAC_P, shift left.
- Activation is applied in the FRAC_P domain. Leaky ReLU is an arithmetic >>>2 on negative values. Clamp limits the value to ±(1<<FRAC_P).
- Requantization from FRAC_P to OUT_FRAC uses round-half-away-from-zero. The result then saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Lane products are sign-extended to ACC_W before the combinational adder tree. The accumulator never wraps within the declared length.
- Idle-state data_valid and active-state cmd_valid are ignored; no stall side effects.

Optional Feature:
NEURON_SAT_FLAG_EN:
- Defined: adds output out_sat (1 bit), registered alongside out_data. It is 1 when the final saturation clipped the value, and held for the same cycles as out_data. Reset value 0.
- Undefined: the port and its logic are absent.

Decomposition:
- Package neuron_pkg:
  - act_sel encoding constants ACT_IDENTITY, ACT_RELU, ACT_LEAKY, ACT_CLAMP
  - LEAK_SHIFT=2
  - state enum (IDLE, ACCUM, OUT)
  - clog2 helper
- Sub-module neuron_lane_dot: combinational LANES-wide masked multiply and adder tree. It takes the lane valid count and returns an ACC_W-bit partial sum.
- Top level: FSM, counters, bias alignment, activation and quantize/saturate.

Test Plan:
- len=4, bias=0, act=00, all x=16, w=16, mask=1111, one beat. out_data=1024 on the cycle after the beat.
- len=6, two beats, all used lanes x=16, w=16, mask=1111. Beat 2 lanes 2,3 carry x=127, w=127 and must be ignored. Repeat with mask bit 1 of beat 1 = 0. Results 1536 and 1280.
- len=0, bias=-512. act 00 gives -512, 01 gives 0, 10 gives -128, 11 gives -256. Each result appears 1 cycle after the command.
- len=16, x=127, w=127 gives 32767. With w=-128 the result is -32768. Under NEURON_SAT_FLAG_EN, out_sat=1 in both cases and 0 for a 1024 result.
- out_ready held low 5 cycles. out_valid and out_data stay stable, and cmd_ready=0 throughout. cmd_ready=1 the cycle after acceptance.
- Assert rst_n low after 2 of 4 beats. All outputs are 0 and cmd_ready=1 after release. The next operation (test 1 stimulus) yields 1024.
